// File: rtl/input_cond_pkg.sv
// Shared types and default constants for the input conditioner.
// Optional auto-repeat is built only when INPUT_COND_REPEAT_EN is defined.
package input_cond_pkg;

  // Per-channel debounce state, exported on the debug port as a 2-bit code.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONF_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_CONF_LO = 2'd3
  } cond_state_e;

  localparam int DEF_NUM_IN            = 4;
  localparam int DEF_DEBOUNCE_CYC      = 500000;
  localparam int DEF_REPEAT_DELAY_CYC  = 25000000;
  localparam int DEF_REPEAT_PERIOD_CYC = 5000000;

  // Bits needed to hold 0..max_count; never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: two-flop synchronizer, debounce FSM with edge pulses,
// and (with INPUT_COND_REPEAT_EN) an auto-repeat generator while held high.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
`ifdef INPUT_COND_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_i,
  output logic        level_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        rpt_o,
  output cond_state_e state_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          s;
  cond_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  // Only sync_q[1] is safe to use; sync_q[0] may be metastable.
  assign s     = sync_q[1];
  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_q <= ST_CONF_HI;
            cnt_q   <= CW'(1);
          end
        end
        ST_CONF_HI: begin
          if (!s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_q <= ST_CONF_LO;
            cnt_q   <= CW'(1);
          end
        end
        ST_CONF_LO: begin
          if (s) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign state_o = state_q;

`ifdef INPUT_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC
                                                               : REPEAT_PERIOD_CYC;
  localparam int            RW        = cnt_width(RMAX - 1);
  localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD_CYC - 1);

  logic [RW-1:0] rcnt_q;
  logic          rphase_q;
  logic          rpt_q;
  logic          rpt_hit;

  // rphase_q selects the initial delay (0) or the steady repeat period (1).
  assign rpt_hit = rphase_q ? (rcnt_q == RPER_LAST) : (rcnt_q == RDLY_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      // Counts only cycles that remain in HIGH; anything else restarts the delay.
      if (state_q == ST_HIGH && s) begin
        if (rpt_hit) begin
          rpt_q    <= 1'b1;
          rphase_q <= 1'b1;
          rcnt_q   <= '0;
        end else begin
          rcnt_q <= rcnt_q + RW'(1);
        end
      end else begin
        rcnt_q   <= '0;
        rphase_q <= 1'b0;
      end
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel key/switch conditioner: independent debounce_channel per input.
// Define INPUT_COND_REPEAT_EN to build the auto-repeat logic; otherwise rpt_o is 0.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_IN            = DEF_NUM_IN,
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IN-1:0]     in_i,
  output logic [NUM_IN-1:0]     level_o,
  output logic [NUM_IN-1:0]     rise_o,
  output logic [NUM_IN-1:0]     fall_o,
  output logic [NUM_IN-1:0]     rpt_o,
  output logic [2*NUM_IN-1:0]   dbg_state_o
);

  if (NUM_IN < 1 || NUM_IN > 32 || DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > (1 << 24) ||
      REPEAT_DELAY_CYC < 1 || REPEAT_PERIOD_CYC < 1) begin : g_bad_param
    $error("input_conditioner: parameter out of range");
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    cond_state_e st;

    debounce_channel #(
      .DEBOUNCE_CYC      (DEBOUNCE_CYC)
`ifdef INPUT_COND_REPEAT_EN
      ,
      .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
      .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_i    (in_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i]),
      .rpt_o   (rpt_o[i]),
      .state_o (st)
    );

    assign dbg_state_o[2*i +: 2] = 2'(st);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (NUM_IN=2, DEBOUNCE=4, DELAY=8, PERIOD=3):
// directed vector table, hand sequences for repeat/reset, randomized run vs model.
module tb_input_conditioner;

  localparam int NI  = 2;
  localparam int DEB = 4;
  localparam int DLY = 8;
  localparam int PER = 3;
`ifdef INPUT_COND_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  // clock / reset
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI-1:0]   in_i = '0;
  logic [NI-1:0]   level_o, rise_o, fall_o, rpt_o;
  logic [2*NI-1:0] dbg_state;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_IN(NI), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY), .REPEAT_PERIOD_CYC(PER)
  ) dut (
    .clk(clk), .rst(rst), .in_i(in_i), .level_o(level_o), .rise_o(rise_o),
    .fall_o(fall_o), .rpt_o(rpt_o), .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: raw input reaches the decision point two edges late; a level is
  // accepted once DEB consecutive samples disagree with it; repeats are timed
  // from the moment the synchronized input last (re)settled high while level=1.
  logic [NI-1:0] m_p1, m_p2, m_lvl, m_rise, m_fall, m_rpt, m_prev;
  int            m_run [NI];
  int            m_age [NI];

  task automatic model_step(input logic r, input logic [NI-1:0] v);
    for (int c = 0; c < NI; c++) begin
      m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_rpt[c] = 1'b0;
      if (r) begin
        m_lvl[c] = 1'b0; m_run[c] = 0; m_age[c] = 0; m_prev[c] = 1'b0;
      end else begin
        logic s;
        s = m_p2[c];
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c]  = s;
            m_rise[c] = s;
            m_fall[c] = !s;
            m_run[c]  = 0;
            m_age[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
          if (s) begin
            if (!m_prev[c]) m_age[c] = 0;
            else begin
              m_age[c]++;
              if (m_age[c] == DLY || (m_age[c] > DLY && (m_age[c] - DLY) % PER == 0))
                m_rpt[c] = REP_ON;
            end
          end
        end
        m_prev[c] = s;
      end
    end
    if (r) begin m_p1 = '0; m_p2 = '0; end
    else begin m_p2 = m_p1; m_p1 = v; end
  endtask

  // driver: called at a negedge; applies inputs, clocks once, returns at next negedge
  task automatic tick(input logic r, input logic [NI-1:0] v);
    rst  = r;
    in_i = v;
    @(posedge clk);
    model_step(r, v);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          r;
    logic [NI-1:0] v;
    logic [NI-1:0] lvl, rise, fall, rpt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_n(input int n, input logic r, input logic [NI-1:0] v,
                                input logic [NI-1:0] lvl, input logic [NI-1:0] rise,
                                input logic [NI-1:0] fall, input logic [NI-1:0] rpt);
    vec_t x;
    x.r = r; x.v = v; x.lvl = lvl; x.rise = rise; x.fall = fall; x.rpt = rpt;
    for (int k = 0; k < n; k++) vecs.push_back(x);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NI-1:0] rp;
    logic          found;
    logic [NI-1:0] cur;
    int            hold [NI];
    rp = {1'b0, REP_ON};

    // Each row: inputs before edge i, outputs expected after edge i.
    add_n(2,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);  // reset
    add_n(10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);  // quiet inputs
    add_n(5,  0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);  // E0 = row 12
    add_n(1,  0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);  // E0+5: accepted
    add_n(1,  0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);  // rise is one cycle
    add_n(5,  0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(1,  0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);  // fall
    add_n(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_n(3,  0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);  // 3-cycle glitch
    add_n(8,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_n(5,  0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);  // both at once, row 37
    add_n(1,  0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);  // row 42: both rise
    add_n(3,  0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(4,  0, 2'b10 ^ 2'b11 ^ 2'b10 ^ 2'b11 ^ 2'b01, 2'b11, 2'b00, 2'b00, 2'b00); // release ch1
    add_n(1,  0, 2'b01, 2'b11, 2'b00, 2'b00, rp);     // row 50: first repeat ch0
    add_n(1,  0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);  // row 51: ch1 fall only
    add_n(1,  0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(1,  0, 2'b01, 2'b01, 2'b00, 2'b00, rp);     // row 53: period repeat

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].r, vecs[i].v);
      check($sformatf("vec%0d level", i), level_o, vecs[i].lvl);
      check($sformatf("vec%0d rise", i),  rise_o,  vecs[i].rise);
      check($sformatf("vec%0d fall", i),  fall_o,  vecs[i].fall);
      check($sformatf("vec%0d rpt", i),   rpt_o,   vecs[i].rpt);
    end

    // Auto-repeat timing relative to the accepted rise.
    tick(1, 2'b00);
    tick(1, 2'b00);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick(0, 2'b01);
      if (rise_o[0]) found = 1'b1;
    end
    check("rpt_rise_seen", found, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick(0, 2'b01);
      check($sformatf("rpt0 k=%0d", k), rpt_o[0],
            REP_ON && (k == DLY || (k > DLY && (k - DLY) % PER == 0)));
      check($sformatf("rpt1 k=%0d", k), rpt_o[1], 1'b0);
    end

    // Reset while level is high: drop without fall, then re-qualify.
    check("pre_rst level0", level_o[0], 1'b1);
    tick(1, 2'b01);
    check("rst level0", level_o[0], 1'b0);
    check("rst fall0",  fall_o[0],  1'b0);
    check("rst rise0",  rise_o[0],  1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick(0, 2'b01);
      check($sformatf("requal level k=%0d", k), level_o[0], k >= DEB + 2);
      check($sformatf("requal rise k=%0d", k),  rise_o[0],  k == DEB + 2);
      check($sformatf("requal fall k=%0d", k),  fall_o[0],  1'b0);
    end

    // Randomized run against the reference model.
    cur = '0;
    for (int c = 0; c < NI; c++) hold[c] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NI; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 16);
        end else hold[c]--;
      end
      tick($urandom_range(0, 99) == 0, cur);
      check($sformatf("rand%0d level", n), level_o, m_lvl);
      check($sformatf("rand%0d rise", n),  rise_o,  m_rise);
      check($sformatf("rand%0d fall", n),  fall_o,  m_fall);
      check($sformatf("rand%0d rpt", n),   rpt_o,   m_rpt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
